ipsmacge_rxintf_mp: RTL and testbench
=====================================

// Module: ipsmacge_rxintf_mp
// PURPOSE
//  N-port receive front end between PHY pads (GMII/MII/RGMII, 10/100/1000) and MAC rx core.
//  Each port: registers pad signals, aligns 10/100 nibbles on the SFD and strips preamble/SFD.
//  Each port outputs a byte stream with sof/eof/error framing and enforces a max-length guard.
// PARAMETERS
//  NPORT   4     number of independent ports
//  DAT_DW  8     byte width; nibble = DAT_DW/2
//  MSP_DW  2     speed field width per port (00=10M, 01=100M, 1x=1000M; 11 reserved)
//  LEN_DW  14    frame byte counter width
//  MAXLEN  1536  max bytes after SFD before forced abort
// PORTS
//  rxclk     in   1            rx clock (one domain for all ports)
//  rxrst_    in   1            reset, asynchronous, active-low
//  rxhdat    in   NPORT*DAT_DW rising-edge pad data, port p at [p*DAT_DW +: DAT_DW]
//  rxldat    in   NPORT*DAT_DW falling-edge pad data
//  rxhctl    in   NPORT        rising-edge dv/ctl
//  rxlctl    in   NPORT        falling-edge ctl
//  rxherr    in   NPORT        rising-edge rx_er (GMII/MII)
//  rxlerr    in   NPORT        falling-edge rx_er (GMII/MII)
//  up_act    in   NPORT        per-port enable
//  up_gmii   in   NPORT        1=GMII/MII, 0=RGMII
//  up_mspd   in   NPORT*MSP_DW per-port speed
//  up_pos    in   1            1=use rising-edge set in GMII/MII and 10/100 modes
//  ogval     out  NPORT        byte valid
//  ogdat     out  NPORT*DAT_DW byte
//  ogsof     out  NPORT        with ogval: first byte after SFD
//  ogeof     out  NPORT        1-cycle end pulse, ogval=0 that cycle
//  oger      out  NPORT        qualifies ogeof: frame bad
//  stat_gfrm out  NPORT*16     good-frame count (macro-gated)
//  stat_efrm out  NPORT*16     bad-frame count (macro-gated)
// BEHAVIOUR
//  - Reset: all outputs 0, all FSMs IDLE, counters 0. Pads go through 2 flop stages (_1, _2).
//  - dv: RGMII dv=hctl_2; GMII/MII dv = up_pos ? hctl_2 : lctl_2.
//  - er: RGMII er=hctl_2^lctl_2; GMII/MII er = up_pos ? herr_2 : lerr_2.
//  - Speed/mode latched per port on IDLE->PRE; mid-frame config changes ignored until IDLE.
//  - 1000M: ogdat = RGMII {l[3:0],h[3:0]} / GMII selected byte; 3 cycles pad->ogdat.
//  - 10/100: one nibble per clock (low nibble first); byte is valid 1 cycle after its high nibble enters _2.
//  - FSM per port:
//    - IDLE: leave on dv=1 -> PRE.
//    - PRE: stay on 0x5 nibbles / 0x55 bytes. On SFD (nibble 0x5 then 0xD, or byte 0xD5) -> DATA.
//      Next nibble is the low half of byte 0. Any other value -> DROP. dv=0 -> IDLE, no eof.
//    - DATA: emit bytes, first with ogsof. er=1 sets sticky ferr.
//      dv falls -> ogeof next cycle, oger=ferr|odd, then IDLE (odd = dangling nibble, discarded).
//      Byte count reaching MAXLEN+1 -> ogeof/oger=1 at once, then DROP.
//    - DROP: no output; dv=0 -> IDLE.
//  - up_act=0: outputs forced 0. If the port is in DATA, emit ogeof/oger=1 first, then IDLE.
//  - Reserved speed: behaves as up_act=0.
//  - dv re-asserting in the eof cycle starts a new frame (IDLE->PRE next cycle); no byte lost.
// CONFIGURATION
//  IPSMACGE_RXINTF_STAT_EN defined:
//    - per-port 16-bit saturating counters. gfrm++ on ogeof&!oger; efrm++ on ogeof&oger.
//    - 0xFFFF holds. Cleared only by reset.
//  Not defined: stat_gfrm/stat_efrm tied to 0, no counter flops.
// TESTING
//  - RGMII 1000M port0: 7x55,D5, 64B 00..3F, dv low -> sof on 00, 64 valids, eof oger=0 one cycle after 3F.
//  - MII 100M port1: nibble 5 x15, D, 0xA,0xB,... -> first byte 0xBA with sof; odd trailing nibble -> oger=1.
//  - GMII 1000M: rx_er pulse mid-frame -> frame bytes pass, ogeof with oger=1; efrm=1 (STAT_EN).
//  - up_act dropped at byte 10 of port2 -> ogeof/oger=1 next cycle, then outputs 0; other ports unaffected.
//  - 1600B frame, MAXLEN=1536 -> 1536 valids, eof/oger=1 at byte 1537, no further output until dv low.
//  - Preamble 0x55,0x33 -> DROP, no sof/eof; back-to-back frame after dv low decodes normally.

Source files
------------

// File: rtl/ipsmacge_rxintf_mp.sv
// N-port GMII/MII/RGMII receive front end: pad retiming, SFD alignment, byte framing, length guard.
// Define IPSMACGE_RXINTF_STAT_EN to build the per-port good/bad frame counters.
module ipsmacge_rxintf_mp #(
   parameter int unsigned NPORT  = 4,
   parameter int unsigned DAT_DW = 8,
   parameter int unsigned MSP_DW = 2,
   parameter int unsigned LEN_DW = 14,
   parameter int unsigned MAXLEN = 1536
) (
   input  logic                      rxclk,
   input  logic                      rxrst_,
   input  logic [NPORT*DAT_DW-1:0]   rxhdat,
   input  logic [NPORT*DAT_DW-1:0]   rxldat,
   input  logic [NPORT-1:0]          rxhctl,
   input  logic [NPORT-1:0]          rxlctl,
   input  logic [NPORT-1:0]          rxherr,
   input  logic [NPORT-1:0]          rxlerr,
   input  logic [NPORT-1:0]          up_act,
   input  logic [NPORT-1:0]          up_gmii,
   input  logic [NPORT*MSP_DW-1:0]   up_mspd,
   input  logic                      up_pos,
   output logic [NPORT-1:0]          ogval,
   output logic [NPORT*DAT_DW-1:0]   ogdat,
   output logic [NPORT-1:0]          ogsof,
   output logic [NPORT-1:0]          ogeof,
   output logic [NPORT-1:0]          oger,
   output logic [NPORT*16-1:0]       stat_gfrm,
   output logic [NPORT*16-1:0]       stat_efrm
);

   localparam int unsigned NIB_DW = DAT_DW / 2;
   localparam int unsigned PAD_W  = 2 * DAT_DW + 4;
   localparam logic [DAT_DW-1:0] PRE_B = DAT_DW'(8'h55);
   localparam logic [DAT_DW-1:0] SFD_B = DAT_DW'(8'hD5);
   localparam logic [NIB_DW-1:0] PRE_N = NIB_DW'(4'h5);
   localparam logic [NIB_DW-1:0] SFD_N = NIB_DW'(4'hD);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   for (genvar g = 0; g < NPORT; g++) begin : gen_port
      logic [PAD_W-1:0]  r_pad_1, r_pad_2;
      logic [DAT_DW-1:0] w_h, w_l;
      logic              w_hctl, w_lctl, w_herr, w_lerr;
      state_t            r_state, n_state;
      logic              r_gmii, n_gmii;
      logic [MSP_DW-1:0] r_spd, n_spd;
      logic              r_p5, n_p5, r_half, n_half, r_ferr, n_ferr;
      logic [NIB_DW-1:0] r_lo, n_lo;
      logic [LEN_DW-1:0] r_len, n_len;
      logic              r_val, n_val, r_sof, n_sof, r_eof, n_eof, r_er, n_er;
      logic [DAT_DW-1:0] r_dat, n_dat;
      logic              w_gmii, w_g1000, w_act, w_dv, w_er, w_bval;
      logic [MSP_DW-1:0] w_spd;
      logic [DAT_DW-1:0] w_byte, w_bdat;
      logic [NIB_DW-1:0] w_nib;

      // Two-stage pad retiming
      always_ff @(posedge rxclk or negedge rxrst_) begin
         if (!rxrst_) begin
            r_pad_1 <= '0;
            r_pad_2 <= '0;
         end else begin
            r_pad_1 <= {rxhdat[g*DAT_DW +: DAT_DW], rxldat[g*DAT_DW +: DAT_DW],
                        rxhctl[g], rxlctl[g], rxherr[g], rxlerr[g]};
            r_pad_2 <= r_pad_1;
         end
      end
      assign {w_h, w_l, w_hctl, w_lctl, w_herr, w_lerr} = r_pad_2;

      // Live config while idle, frozen copy for the rest of the frame
      assign w_gmii  = (r_state == S_IDLE) ? up_gmii[g] : r_gmii;
      assign w_spd   = (r_state == S_IDLE) ? up_mspd[g*MSP_DW +: MSP_DW] : r_spd;
      assign w_g1000 = w_spd[MSP_DW-1];
      assign w_act   = up_act[g] && (w_spd != {MSP_DW{1'b1}});
      assign w_dv    = w_gmii ? (up_pos ? w_hctl : w_lctl) : w_hctl;
      assign w_er    = w_gmii ? (up_pos ? w_herr : w_lerr) : (w_hctl ^ w_lctl);
      assign w_byte  = w_gmii ? (up_pos ? w_h : w_l) : {w_l[NIB_DW-1:0], w_h[NIB_DW-1:0]};
      assign w_nib   = (w_gmii && !up_pos) ? w_l[NIB_DW-1:0] : w_h[NIB_DW-1:0];

      always_ff @(posedge rxclk or negedge rxrst_) begin
         if (!rxrst_) begin
            r_state <= S_IDLE;
            r_gmii  <= 1'b0;
            r_spd   <= '0;
            r_p5    <= 1'b0;
            r_half  <= 1'b0;
            r_ferr  <= 1'b0;
            r_lo    <= '0;
            r_len   <= '0;
            r_val   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_er    <= 1'b0;
            r_dat   <= '0;
         end else begin
            r_state <= n_state;
            r_gmii  <= n_gmii;
            r_spd   <= n_spd;
            r_p5    <= n_p5;
            r_half  <= n_half;
            r_ferr  <= n_ferr;
            r_lo    <= n_lo;
            r_len   <= n_len;
            r_val   <= n_val;
            r_sof   <= n_sof;
            r_eof   <= n_eof;
            r_er    <= n_er;
            r_dat   <= n_dat;
         end
      end

      always_comb begin
         n_state = r_state;
         n_gmii  = r_gmii;
         n_spd   = r_spd;
         n_p5    = r_p5;
         n_half  = r_half;
         n_ferr  = r_ferr;
         n_lo    = r_lo;
         n_len   = r_len;
         n_val   = 1'b0;
         n_sof   = 1'b0;
         n_eof   = 1'b0;
         n_er    = 1'b0;
         n_dat   = '0;
         w_bval  = 1'b0;
         w_bdat  = w_byte;
         if (!w_act) begin
            // Disabled port: close an open frame as bad, otherwise stay silent
            if (r_state == S_DATA) begin
               n_eof = 1'b1;
               n_er  = 1'b1;
            end
            n_state = S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_dv) begin
                     n_state = S_PRE;
                     n_gmii  = up_gmii[g];
                     n_spd   = up_mspd[g*MSP_DW +: MSP_DW];
                     n_p5    = (w_nib == PRE_N);
                  end
               end
               S_PRE: begin
                  n_half = 1'b0;
                  n_ferr = 1'b0;
                  n_len  = '0;
                  if (!w_dv) begin
                     n_state = S_IDLE;
                  end else if (w_g1000) begin
                     if (w_byte == SFD_B)      n_state = S_DATA;
                     else if (w_byte != PRE_B) n_state = S_DROP;
                  end else begin
                     if (w_nib == PRE_N)              n_p5    = 1'b1;
                     else if (w_nib == SFD_N && r_p5) n_state = S_DATA;
                     else                             n_state = S_DROP;
                  end
               end
               S_DATA: begin
                  if (!w_dv) begin
                     n_eof   = 1'b1;
                     n_er    = r_ferr | r_half;
                     n_state = S_IDLE;
                  end else begin
                     if (w_er) n_ferr = 1'b1;
                     if (w_g1000) begin
                        w_bval = 1'b1;
                     end else if (r_half) begin
                        w_bval = 1'b1;
                        w_bdat = {w_nib, r_lo};
                        n_half = 1'b0;
                     end else begin
                        n_lo   = w_nib;
                        n_half = 1'b1;
                     end
                     if (w_bval) begin
                        if (r_len == LEN_DW'(MAXLEN)) begin
                           n_eof   = 1'b1;
                           n_er    = 1'b1;
                           n_state = S_DROP;
                        end else begin
                           n_val = 1'b1;
                           n_dat = w_bdat;
                           n_sof = (r_len == '0);
                           n_len = r_len + LEN_DW'(1);
                        end
                     end
                  end
               end
               S_DROP: begin
                  if (!w_dv) n_state = S_IDLE;
               end
               default: n_state = S_IDLE;
            endcase
         end
      end

      assign ogval[g]                   = r_val;
      assign ogdat[g*DAT_DW +: DAT_DW]  = r_dat;
      assign ogsof[g]                   = r_sof;
      assign ogeof[g]                   = r_eof;
      assign oger[g]                    = r_er;

`ifdef IPSMACGE_RXINTF_STAT_EN
      logic [15:0] r_gcnt, r_ecnt;
      // Saturating frame counters, cleared only by reset
      always_ff @(posedge rxclk or negedge rxrst_) begin
         if (!rxrst_) begin
            r_gcnt <= '0;
            r_ecnt <= '0;
         end else begin
            if (r_eof && !r_er && r_gcnt != 16'hFFFF) r_gcnt <= r_gcnt + 16'd1;
            if (r_eof && r_er && r_ecnt != 16'hFFFF)  r_ecnt <= r_ecnt + 16'd1;
         end
      end
      assign stat_gfrm[g*16 +: 16] = r_gcnt;
      assign stat_efrm[g*16 +: 16] = r_ecnt;
`else
      assign stat_gfrm[g*16 +: 16] = 16'h0000;
      assign stat_efrm[g*16 +: 16] = 16'h0000;
`endif
   end

endmodule

// File: tb/tb_ipsmacge_rxintf_mp.sv
// Scoreboard bench for ipsmacge_rxintf_mp: per-port pad-beat stimulus queues and expected-output queues.
module tb_ipsmacge_rxintf_mp;
   localparam int unsigned NP = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned MW = 2;
   localparam int MAXLEN = 1536;

   typedef struct packed {
      logic       mark;
      logic       hctl, lctl, herr, lerr;
      logic [7:0] h, l;
   } beat_t;

   typedef struct packed {
      logic       eof, err, sof, tight;
      logic [7:0] dat;
   } exp_t;

   logic               rxclk = 1'b0;
   logic               rxrst_ = 1'b0;
   logic [NP*DW-1:0]   rxhdat = '0, rxldat = '0;
   logic [NP-1:0]      rxhctl = '0, rxlctl = '0, rxherr = '0, rxlerr = '0;
   logic [NP-1:0]      up_act = '1, up_gmii = '0;
   logic [NP*MW-1:0]   up_mspd = {NP{2'b10}};
   logic               up_pos = 1'b1;
   logic [NP-1:0]      ogval, ogsof, ogeof, oger;
   logic [NP*DW-1:0]   ogdat;
   logic [NP*16-1:0]   stat_gfrm, stat_efrm;

   beat_t sq[NP][$];
   exp_t  eq[NP][$];
   int    checks = 0, errors = 0, cyc = 0;
   int    drv_cyc[NP], sof_cyc[NP], last_cyc[NP], exp_g[NP], exp_e[NP];

   ipsmacge_rxintf_mp dut (
      .rxclk(rxclk), .rxrst_(rxrst_), .rxhdat(rxhdat), .rxldat(rxldat),
      .rxhctl(rxhctl), .rxlctl(rxlctl), .rxherr(rxherr), .rxlerr(rxlerr),
      .up_act(up_act), .up_gmii(up_gmii), .up_mspd(up_mspd), .up_pos(up_pos),
      .ogval(ogval), .ogdat(ogdat), .ogsof(ogsof), .ogeof(ogeof), .oger(oger),
      .stat_gfrm(stat_gfrm), .stat_efrm(stat_efrm));

   always #5 rxclk = ~rxclk;
   always @(posedge rxclk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic beat_t b_rg(input logic [7:0] d, input logic er);
      beat_t b = '0;
      b.hctl = 1'b1; b.lctl = 1'b1 ^ er; b.herr = 1'b1; b.lerr = 1'b1;
      b.h = {4'hC, d[3:0]}; b.l = {4'h3, d[7:4]};
      return b;
   endfunction

   // Selected edge carries the real beat, the other edge carries a decoy
   function automatic beat_t b_gm(input logic [7:0] d, input logic er, input logic pos);
      beat_t b = '0;
      if (pos) begin
         b.h = d; b.hctl = 1'b1; b.herr = er; b.l = ~d; b.lctl = 1'b0; b.lerr = ~er;
      end else begin
         b.l = d; b.lctl = 1'b1; b.lerr = er; b.h = ~d; b.hctl = 1'b0; b.herr = ~er;
      end
      return b;
   endfunction

   function automatic beat_t b_1g(input logic rg, input logic pos, input logic [7:0] d, input logic er);
      return rg ? b_rg(d, er) : b_gm(d, er, pos);
   endfunction

   task automatic pre1g(input int p, input logic rg, input logic pos);
      for (int i = 0; i < 7; i++) sq[p].push_back(b_1g(rg, pos, 8'h55, 1'b0));
      sq[p].push_back(b_1g(rg, pos, 8'hD5, 1'b0));
   endtask

   task automatic pre_mii(input int p, input logic pos);
      for (int i = 0; i < 15; i++) sq[p].push_back(b_gm({4'h9, 4'h5}, 1'b0, pos));
      sq[p].push_back(b_gm({4'h9, 4'hD}, 1'b0, pos));
   endtask

   task automatic mii_byte(input int p, input logic pos, input logic [7:0] d);
      sq[p].push_back(b_gm({4'h9, d[3:0]}, 1'b0, pos));
      sq[p].push_back(b_gm({4'h9, d[7:4]}, 1'b0, pos));
   endtask

   task automatic idle(input int p, input int n);
      for (int i = 0; i < n; i++) sq[p].push_back('0);
   endtask

   task automatic xb(input int p, input logic [7:0] d, input logic sof);
      exp_t e = '0;
      e.dat = d; e.sof = sof;
      eq[p].push_back(e);
   endtask

   task automatic xe(input int p, input logic err, input logic tight);
      exp_t e = '0;
      e.eof = 1'b1; e.err = err; e.tight = tight;
      eq[p].push_back(e);
   endtask

   task automatic cfg(input int p, input logic gm, input logic [1:0] spd);
      up_gmii[p] = gm;
      up_mspd[p*MW +: MW] = spd;
   endtask

   task automatic drive(input int p, input beat_t b);
      rxhdat[p*DW +: DW] = b.h;  rxldat[p*DW +: DW] = b.l;
      rxhctl[p] = b.hctl; rxlctl[p] = b.lctl; rxherr[p] = b.herr; rxlerr[p] = b.lerr;
   endtask

   // Drive all port queues one beat per cycle and score DUT output against expected queues
   task automatic run(input int extra, input int drop_it, input int drop_p);
      int it = 0, tail = 0;
      bit busy;
      exp_t e;
      beat_t b;
      while (tail < extra && it < 5000) begin
         @(negedge rxclk);
         for (int p = 0; p < NP; p++) begin
            if (ogval[p] || ogeof[p] || oger[p]) begin
               checks++;
               if (eq[p].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out p%0d: got val=%b eof=%b er=%b dat=%h, required no output",
                           p, ogval[p], ogeof[p], oger[p], ogdat[p*DW +: DW]);
               end else begin
                  e = eq[p].pop_front();
                  if (e.eof) begin
                     if (e.err) exp_e[p]++; else exp_g[p]++;
                     if (ogeof[p] !== 1'b1 || ogval[p] !== 1'b0 || oger[p] !== e.err ||
                         (e.tight && (cyc - last_cyc[p] != 1))) begin
                        errors++;
                        $display("FAIL eof p%0d: got val=%b eof=%b er=%b gap=%0d, required eof=1 er=%b gap=%s",
                                 p, ogval[p], ogeof[p], oger[p], cyc - last_cyc[p], e.err, e.tight ? "1" : "any");
                     end
                  end else begin
                     if (ogval[p] !== 1'b1 || ogeof[p] !== 1'b0 || oger[p] !== 1'b0 ||
                         ogdat[p*DW +: DW] !== e.dat || ogsof[p] !== e.sof) begin
                        errors++;
                        $display("FAIL byte p%0d: got val=%b eof=%b dat=%h sof=%b, required val=1 dat=%h sof=%b",
                                 p, ogval[p], ogeof[p], ogdat[p*DW +: DW], ogsof[p], e.dat, e.sof);
                     end
                     last_cyc[p] = cyc;
                     if (e.sof) sof_cyc[p] = cyc;
                  end
               end
            end
         end
         if (it == drop_it) up_act[drop_p] = 1'b0;
         busy = 1'b0;
         for (int p = 0; p < NP; p++) begin
            b = '0;
            if (sq[p].size() > 0) begin
               b = sq[p].pop_front();
               busy = 1'b1;
               if (b.mark) drv_cyc[p] = cyc;
            end
            drive(p, b);
         end
         if (!busy) tail++;
         it++;
      end
      checks++;
      if (it >= 5000) begin
         errors++;
         $display("FAIL run_timeout: got %0d iterations, required < 5000", it);
      end
      for (int p = 0; p < NP; p++) begin
         checks++;
         if (eq[p].size() != 0) begin
            errors++;
            $display("FAIL missing_out p%0d: got %0d expected items left, required 0", p, eq[p].size());
         end
         eq[p].delete();
         sq[p].delete();
      end
   endtask

   task automatic test_reset();
      rxrst_ = 1'b0;
      rxhdat = '1; rxldat = '1; rxhctl = '1; rxlctl = '0; rxherr = '1; rxlerr = '1;
      repeat (3) @(negedge rxclk);
      checks += 5;
      if (ogval !== '0)     begin errors++; $display("FAIL reset_ogval: got %h, required 0", ogval); end
      if (ogdat !== '0)     begin errors++; $display("FAIL reset_ogdat: got %h, required 0", ogdat); end
      if ({ogsof, ogeof, oger} !== '0)
                            begin errors++; $display("FAIL reset_flags: got %h, required 0", {ogsof, ogeof, oger}); end
      if (stat_gfrm !== '0) begin errors++; $display("FAIL reset_gfrm: got %h, required 0", stat_gfrm); end
      if (stat_efrm !== '0) begin errors++; $display("FAIL reset_efrm: got %h, required 0", stat_efrm); end
      rxhdat = '0; rxldat = '0; rxhctl = '0; rxlctl = '0; rxherr = '0; rxlerr = '0;
      @(negedge rxclk);
      rxrst_ = 1'b1;
      repeat (3) @(negedge rxclk);
   endtask

   task automatic test_rgmii_1000();
      beat_t b;
      cfg(0, 1'b0, 2'b10);
      pre1g(0, 1'b1, 1'b0);
      for (int i = 0; i < 64; i++) begin
         b = b_rg(8'(i), 1'b0);
         b.mark = (i == 0);
         sq[0].push_back(b);
         xb(0, 8'(i), i == 0);
      end
      idle(0, 1);
      xe(0, 1'b0, 1'b1);
      run(8, -1, 0);
      checks++;
      if (sof_cyc[0] - drv_cyc[0] != 3) begin
         errors++;
         $display("FAIL rgmii_latency: got %0d cycles pad->ogdat, required 3", sof_cyc[0] - drv_cyc[0]);
      end
   endtask

   task automatic test_mii_100();
      logic [7:0] d[5];
      d = '{8'hBA, 8'hDC, 8'hFE, 8'h10, 8'h32};
      up_pos = 1'b1;
      cfg(1, 1'b1, 2'b01);
      pre_mii(1, 1'b1);
      for (int i = 0; i < 5; i++) begin mii_byte(1, 1'b1, d[i]); xb(1, d[i], i == 0); end
      sq[1].push_back(b_gm({4'h9, 4'h7}, 1'b0, 1'b1));
      idle(1, 1);
      xe(1, 1'b1, 1'b0);
      run(8, -1, 0);
   endtask

   task automatic test_mii_10_neg();
      logic [7:0] d[3];
      d = '{8'h12, 8'h34, 8'h56};
      up_pos = 1'b0;
      cfg(3, 1'b1, 2'b00);
      pre_mii(3, 1'b0);
      for (int i = 0; i < 3; i++) begin mii_byte(3, 1'b0, d[i]); xb(3, d[i], i == 0); end
      idle(3, 1);
      xe(3, 1'b0, 1'b1);
      run(8, -1, 0);
   endtask

   task automatic test_gmii_err();
      up_pos = 1'b0;
      cfg(3, 1'b1, 2'b10);
      pre1g(3, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         sq[3].push_back(b_gm(8'(8'hA0 + i), i == 7, 1'b0));
         xb(3, 8'(8'hA0 + i), i == 0);
      end
      idle(3, 1);
      xe(3, 1'b1, 1'b1);
      run(8, -1, 0);
   endtask

   // Port 2 disabled when its 10th byte is seen; port 0 keeps running
   task automatic test_act_drop();
      up_pos = 1'b1;
      cfg(2, 1'b1, 2'b10);
      pre1g(2, 1'b0, 1'b1);
      pre1g(0, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) begin
         sq[2].push_back(b_gm(8'(8'h40 + i), 1'b0, 1'b1));
         if (i < 10) xb(2, 8'(8'h40 + i), i == 0);
      end
      xe(2, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) begin
         sq[0].push_back(b_rg(8'(8'hF0 - i), 1'b0));
         xb(0, 8'(8'hF0 - i), i == 0);
      end
      idle(0, 1);
      idle(2, 1);
      xe(0, 1'b0, 1'b1);
      run(8, 8 + 9 + 3, 2);
      up_act[2] = 1'b1;
   endtask

   task automatic test_maxlen();
      cfg(0, 1'b0, 2'b10);
      pre1g(0, 1'b1, 1'b0);
      for (int i = 0; i < 1600; i++) begin
         sq[0].push_back(b_rg(8'(i), 1'b0));
         if (i < MAXLEN) xb(0, 8'(i), i == 0);
      end
      idle(0, 1);
      xe(0, 1'b1, 1'b1);
      run(8, -1, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bad[5];
      bad = '{8'h55, 8'h55, 8'h33, 8'hD5, 8'h01};
      up_pos = 1'b1;
      cfg(1, 1'b1, 2'b10);
      for (int i = 0; i < 5; i++) sq[1].push_back(b_gm(bad[i], 1'b0, 1'b1));
      idle(1, 1);
      pre1g(1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin sq[1].push_back(b_gm(8'(8'h80 + i), 1'b0, 1'b1)); xb(1, 8'(8'h80 + i), i == 0); end
      idle(1, 1);
      xe(1, 1'b0, 1'b1);
      pre1g(1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin sq[1].push_back(b_gm(8'(8'h90 + i), 1'b0, 1'b1)); xb(1, 8'(8'h90 + i), i == 0); end
      idle(1, 1);
      xe(1, 1'b0, 1'b1);
      run(8, -1, 0);
   endtask

   task automatic test_reserved();
      up_pos = 1'b1;
      cfg(3, 1'b1, 2'b11);
      pre1g(3, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) sq[3].push_back(b_gm(8'(i), 1'b0, 1'b1));
      idle(3, 1);
      run(8, -1, 0);
      cfg(3, 1'b1, 2'b10);
   endtask

   task automatic test_stats();
      int eg, ee;
      repeat (2) @(negedge rxclk);
      for (int p = 0; p < NP; p++) begin
`ifdef IPSMACGE_RXINTF_STAT_EN
         eg = exp_g[p]; ee = exp_e[p];
`else
         eg = 0; ee = 0;
`endif
         checks += 2;
         if (stat_gfrm[p*16 +: 16] !== 16'(eg)) begin
            errors++; $display("FAIL stat_gfrm p%0d: got %0d, required %0d", p, stat_gfrm[p*16 +: 16], eg);
         end
         if (stat_efrm[p*16 +: 16] !== 16'(ee)) begin
            errors++; $display("FAIL stat_efrm p%0d: got %0d, required %0d", p, stat_efrm[p*16 +: 16], ee);
         end
      end
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         drv_cyc[p] = 0; sof_cyc[p] = 0; last_cyc[p] = 0; exp_g[p] = 0; exp_e[p] = 0;
      end
      test_reset();
      test_rgmii_1000();
      test_mii_100();
      test_mii_10_neg();
      test_gmii_err();
      test_act_drop();
      test_maxlen();
      test_back_to_back();
      test_reserved();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
